// File: rtl/n64_readcmd_tx.sv
// N64 controller poll transmitter: sends the command byte with pulse-width encoding,
// then the console stop bit, then opens the receiver sample window and pulses done.
module n64_readcmd_tx #(
    parameter logic [7:0]  CMD       = 8'h01,
    parameter int unsigned RX_WINDOW = 640
) (
    input  logic clk_4M,
    input  logic reset,
    input  logic start,
    output logic dq_low,
    output logic rx_en,
    output logic busy,
    output logic done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_STOP,
        S_RX,
        S_DONE
    } state_t;

    localparam logic [15:0] RX_LOAD   = 16'(RX_WINDOW);
    localparam logic [3:0]  PH_LAST   = 4'd15;
    localparam logic [3:0]  STOP_LAST = 4'd7;
    localparam logic [3:0]  LOW_ONE   = 4'd4;
    localparam logic [3:0]  LOW_ZERO  = 4'd12;

    state_t      r_state,   w_state_next;
    logic [3:0]  r_phase,   w_phase_next;
    logic [2:0]  r_bit_idx, w_bit_idx_next;
    logic [7:0]  r_shift,   w_shift_next;
    logic [15:0] r_rx_cnt,  w_rx_cnt_next;

    logic r_dq_low, w_dq_low_next;
    logic r_rx_en,  w_rx_en_next;
    logic r_busy,   w_busy_next;
    logic r_done,   w_done_next;

    // Next-state and counter update.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        w_state_next   = r_state;
        w_phase_next   = r_phase;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_rx_cnt_next  = r_rx_cnt;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next   = S_SEND;
                    w_phase_next   = 4'd0;
                    w_bit_idx_next = 3'd7;
                    w_shift_next   = CMD;
                end
            end
            S_SEND: begin
                if (r_phase == PH_LAST) begin
                    w_phase_next = 4'd0;
                    if (r_bit_idx == 3'd0) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx - 3'd1;
                        w_shift_next   = {r_shift[6:0], 1'b0};
                    end
                end else begin
                    w_phase_next = r_phase + 4'd1;
                end
            end
            S_STOP: begin
                if (r_phase == STOP_LAST) begin
                    w_state_next  = S_RX;
                    w_phase_next  = 4'd0;
                    w_rx_cnt_next = RX_LOAD;
                end else begin
                    w_phase_next = r_phase + 4'd1;
                end
            end
            S_RX: begin
                if (r_rx_cnt == 16'd1) begin
                    w_state_next  = S_DONE;
                    w_rx_cnt_next = 16'd0;
                end else begin
                    w_rx_cnt_next = r_rx_cnt - 16'd1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they can be registered without a cycle of lag.
    always_comb begin
        w_dq_low_next = 1'b0;
        w_rx_en_next  = 1'b0;
        w_busy_next   = 1'b0;
        w_done_next   = 1'b0;

        case (w_state_next)
            S_SEND: begin
                w_busy_next   = 1'b1;
                w_dq_low_next = w_shift_next[7] ? (w_phase_next < LOW_ONE)
                                                : (w_phase_next < LOW_ZERO);
            end
            S_STOP: begin
                w_busy_next   = 1'b1;
                w_dq_low_next = (w_phase_next < LOW_ONE);
            end
            S_RX: begin
                w_busy_next  = 1'b1;
                w_rx_en_next = 1'b1;
            end
            S_DONE: begin
                w_busy_next = 1'b1;
                w_done_next = 1'b1;
            end
            default: begin
                w_busy_next = 1'b0;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_4M) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_phase   <= 4'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_rx_cnt  <= 16'd0;
            r_dq_low  <= 1'b0;
            r_rx_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_phase   <= w_phase_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_rx_cnt  <= w_rx_cnt_next;
            r_dq_low  <= w_dq_low_next;
            r_rx_en   <= w_rx_en_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
        end
    end

    assign dq_low = r_dq_low;
    assign rx_en  = r_rx_en;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_n64_readcmd_tx.sv
// Bench for n64_readcmd_tx: three parameterisations checked cycle by cycle against
// a waveform built directly from the pulse-width encoding rules.
module tb_n64_readcmd_tx;

    logic       clk_4M = 1'b0;
    logic       reset  = 1'b1;
    logic [2:0] start_v = 3'b000;
    logic [2:0] dq_v, rx_v, busy_v, done_v;

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0] exp_q[$];

    always #5 clk_4M = ~clk_4M;

    n64_readcmd_tx u_def (
        .clk_4M(clk_4M), .reset(reset), .start(start_v[0]),
        .dq_low(dq_v[0]), .rx_en(rx_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    n64_readcmd_tx #(.CMD(8'hFF), .RX_WINDOW(16)) u_ff (
        .clk_4M(clk_4M), .reset(reset), .start(start_v[1]),
        .dq_low(dq_v[1]), .rx_en(rx_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    n64_readcmd_tx #(.CMD(8'hA5), .RX_WINDOW(1)) u_a5 (
        .clk_4M(clk_4M), .reset(reset), .start(start_v[2]),
        .dq_low(dq_v[2]), .rx_en(rx_v[2]), .busy(busy_v[2]), .done(done_v[2])
    );

    function automatic logic [3:0] obs(input int sel);
        return {dq_v[sel], rx_v[sel], busy_v[sel], done_v[sel]};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Expected {dq_low, rx_en, busy, done} for cycles 1..N after the start edge.
    task automatic build_model(input logic [7:0] cmd, input int rxw);
        logic [7:0] c;
        int low;
        c = cmd;
        exp_q.delete();
        for (int b = 7; b >= 0; b--) begin
            low = c[b] ? 4 : 12;
            for (int p = 0; p < 16; p++) exp_q.push_back({(p < low), 1'b0, 1'b1, 1'b0});
        end
        for (int p = 0; p < 8; p++) exp_q.push_back({(p < 4), 1'b0, 1'b1, 1'b0});
        for (int p = 0; p < rxw; p++) exp_q.push_back(4'b0110);
        exp_q.push_back(4'b0011);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_4M);
            check($sformatf("idle c%0d", i), {obs(0), obs(1), obs(2)}, 12'h000);
        end
    endtask

    task automatic run_frame(input int sel, input logic [7:0] cmd, input int rxw, input bit spurious);
        int n;
        int dones;
        build_model(cmd, rxw);
        n = exp_q.size();
        dones = 0;
        @(negedge clk_4M);
        start_v[sel] = 1'b1;
        for (int i = 1; i <= n + 1; i++) begin
            @(negedge clk_4M);
            start_v[sel] = spurious && (i >= 2) && (i < n) &&
                           ((i == 20) || (i == n - 5) || ($urandom_range(0, 5) == 0));
            check($sformatf("frame%0d c%0d", sel, i), obs(sel), (i <= n) ? exp_q[i-1] : 4'b0000);
            if (done_v[sel]) dones++;
        end
        start_v[sel] = 1'b0;
        check($sformatf("frame%0d done count", sel), dones, 1);
    endtask

    task automatic reset_mid(input int sel, input logic [7:0] cmd, input int rxw, input int rcyc);
        int seen;
        build_model(cmd, rxw);
        seen = 0;
        @(negedge clk_4M);
        start_v[sel] = 1'b1;
        for (int i = 1; i <= rcyc; i++) begin
            @(negedge clk_4M);
            start_v[sel] = 1'b0;
            check($sformatf("prereset%0d c%0d", sel, i), obs(sel), exp_q[i-1]);
        end
        reset = 1'b1;
        @(negedge clk_4M);
        reset = 1'b0;
        check($sformatf("postreset%0d", sel), obs(sel), 4'b0000);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_4M);
            if (rx_v[sel] || done_v[sel] || busy_v[sel]) seen++;
        end
        check($sformatf("quiet after reset%0d", sel), seen, 0);
    endtask

    task automatic hold_start(input int cycles);
        int period;
        int idx;
        int dones;
        build_model(8'h01, 640);
        period = exp_q.size() + 1;
        dones = 0;
        @(negedge clk_4M);
        start_v[0] = 1'b1;
        for (int i = 1; i <= cycles; i++) begin
            @(negedge clk_4M);
            idx = (i - 1) % period;
            check($sformatf("hold c%0d", i), obs(0), (idx < period - 1) ? exp_q[idx] : 4'b0000);
            check($sformatf("hold excl c%0d", i), dq_v[0] & rx_v[0], 1'b0);
            if (done_v[0]) dones++;
        end
        start_v[0] = 1'b0;
        check("hold done count", dones, cycles / period);
        reset = 1'b1;
        @(negedge clk_4M);
        reset = 1'b0;
        check("hold cleanup", obs(0), 4'b0000);
    endtask

    initial begin
        // Reset held with start asserted everywhere: nothing may launch.
        start_v = 3'b111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_4M);
            check($sformatf("reset c%0d", i), {obs(0), obs(1), obs(2)}, 12'h000);
        end
        reset   = 1'b0;
        start_v = 3'b000;
        idle_cycles(3);

        run_frame(0, 8'h01, 640, 1'b0);
        idle_cycles($urandom_range(1, 5));
        run_frame(0, 8'h01, 640, 1'b1);
        idle_cycles($urandom_range(1, 5));
        reset_mid(0, 8'h01, 640, 50);
        run_frame(0, 8'h01, 640, 1'b0);
        hold_start(2000);
        idle_cycles(2);

        run_frame(1, 8'hFF, 16, 1'b0);
        idle_cycles($urandom_range(1, 5));
        run_frame(1, 8'hFF, 16, 1'b1);
        idle_cycles($urandom_range(1, 5));

        run_frame(2, 8'hA5, 1, 1'b0);
        reset_mid(2, 8'hA5, 1, $urandom_range(1, 137));
        run_frame(2, 8'hA5, 1, 1'b1);
        idle_cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
